// File: rtl/seg_scan_mux.sv
// Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
// Each digit slot starts with a blanking gap; the cathode bus is latched once per frame.
module seg_scan_mux #(
    parameter int DIGITS       = 8,
    parameter int DIV_CYCLES   = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS*8-1:0]   display,
    input  logic [DIGITS-1:0]     digit_en,
    output logic [DIGITS-1:0]     anode,
    output logic [7:0]            cathode,
    output logic                  frame_tick
);

    localparam int CNT_W = $clog2(DIV_CYCLES);
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(DIGITS - 1);

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_e;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    state_e              state_q, state_d;
    logic [DIGITS*8-1:0] shadow_q, shadow_d;
    logic                started_q, started_d;
    logic [DIGITS-1:0]   anode_q, anode_d;
    logic [7:0]          cathode_q, cathode_d;
    logic                tick_q, tick_d;

    // The first edge after reset holds slot 0 / count 0 so that it can take the
    // initial snapshot and raise frame_tick; counting starts on the following edge.
    always_comb begin
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        state_d   = state_q;
        shadow_d  = shadow_q;
        started_d = 1'b1;
        anode_d   = '1;
        cathode_d = 8'hFF;
        tick_d    = 1'b0;

        if (!started_q) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = BLANK;
        end else begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end

            case (state_q)
                BLANK:   if (cnt_q == CNT_BLANK_LAST) state_d = DRIVE;
                DRIVE:   if (cnt_q == CNT_LAST)       state_d = BLANK;
                default: state_d = BLANK;
            endcase
        end

        if (cnt_d == '0 && idx_d == '0) begin
            shadow_d = display;
            tick_d   = 1'b1;
        end

        // Slot 0 always opens in BLANK, so shadow_q is already current whenever a digit is driven.
        if (state_d == DRIVE && digit_en[idx_d]) begin
            anode_d   = ~(DIGITS'(1) << idx_d);
            cathode_d = shadow_q[idx_d*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            state_q   <= BLANK;
            shadow_q  <= '1;
            started_q <= 1'b0;
            anode_q   <= '1;
            cathode_q <= 8'hFF;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            started_q <= started_d;
            anode_q   <= anode_d;
            cathode_q <= cathode_d;
            tick_q    <= tick_d;
        end
    end

    assign anode      = anode_q;
    assign cathode    = cathode_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux (4 digits, 8-cycle slots, 2-cycle blanking): frame/slot model
// derived from elapsed cycles plus literal checkpoints from the scan timing.
module tb_seg_scan_mux;

    localparam int DIGITS = 4;
    localparam int DIV    = 8;
    localparam int BLANK  = 2;
    localparam int FRAME  = DIGITS * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] display = 32'h0;
    logic [3:0]  digit_en = 4'hF;
    logic [3:0]  anode;
    logic [7:0]  cathode;
    logic        frame_tick;

    int nVec = 0;
    int nMis = 0;

    bit          running = 1'b0;
    int          t = 0;
    logic [31:0] snap = '1;
    logic [3:0]  enModel = 4'hF;

    seg_scan_mux #(
        .DIGITS      (DIGITS),
        .DIV_CYCLES  (DIV),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .display   (display),
        .digit_en  (digit_en),
        .anode     (anode),
        .cathode   (cathode),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Model: t counts cycles since reset release; slot, phase and frame follow by division.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            running = 1'b0;
        end else begin
            if (!running) begin
                running = 1'b1;
                t = 0;
            end else begin
                t = t + 1;
            end
            enModel = digit_en;
            if (t % FRAME == 0) snap = display;
        end
    end

    task automatic checkValue(input string name, input logic [7:0] act, input logic [7:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, t, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] eA, input logic [7:0] eC,
                               input logic eF);
        checkValue({tag, " anode"}, {4'h0, anode}, {4'h0, eA});
        checkValue({tag, " cathode"}, cathode, eC);
        checkValue({tag, " frame_tick"}, {7'h0, frame_tick}, {7'h0, eF});
    endtask

    always @(negedge clk) begin : compare
        logic [3:0] eA;
        logic [7:0] eC;
        logic       eF;
        int         ph;
        int         sl;
        eA = 4'hF;
        eC = 8'hFF;
        eF = 1'b0;
        if (rst && running) begin
            ph = t % DIV;
            sl = (t / DIV) % DIGITS;
            if (ph >= BLANK && enModel[sl]) begin
                eA = ~(4'b0001 << sl);
                eC = snap[sl*8 +: 8];
            end
            eF = (t % FRAME == 0);
        end
        checkOutput("model", eA, eC, eF);
        nVec++;
        if (!(anode == 4'hF || $countones(~anode) == 1)) begin
            nMis++;
            $display("[TB] FAIL onehot at cycle %0d: got anode %h, required all-high or one low", t, anode);
        end
    end

    task automatic toCycle(input int k);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(running && t == k) && guard < 500);
        if (!(running && t == k)) begin
            nVec++;
            nMis++;
            $display("[TB] FAIL reach-cycle: got cycle %0d, expected %0d", t, k);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] d, input logic [3:0] e);
        @(posedge clk);
        #2;
        display  = d;
        digit_en = e;
    endtask

    initial begin
        #1 rst = 1'b0;
        display  = 32'h11223344;
        digit_en = 4'hF;
        repeat (3) @(negedge clk);
        checkOutput("reset", 4'hF, 8'hFF, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;

        toCycle(0);  checkOutput("c0",  4'hF, 8'hFF, 1'b1);
        toCycle(1);  checkOutput("c1",  4'hF, 8'hFF, 1'b0);
        toCycle(2);  checkOutput("c2",  4'hE, 8'h44, 1'b0);
        toCycle(7);  checkOutput("c7",  4'hE, 8'h44, 1'b0);
        toCycle(8);  checkOutput("c8",  4'hF, 8'hFF, 1'b0);
        toCycle(10); checkOutput("c10", 4'hD, 8'h33, 1'b0);
        toCycle(11);
        applyStimulus(32'hAABBCCDD, 4'hF);
        toCycle(15); checkOutput("c15", 4'hD, 8'h33, 1'b0);
        toCycle(18); checkOutput("c18", 4'hB, 8'h22, 1'b0);
        toCycle(26); checkOutput("c26", 4'h7, 8'h11, 1'b0);
        toCycle(31); checkOutput("c31", 4'h7, 8'h11, 1'b0);
        toCycle(32); checkOutput("c32", 4'hF, 8'hFF, 1'b1);
        toCycle(34); checkOutput("c34", 4'hE, 8'hDD, 1'b0);
        toCycle(42); checkOutput("c42", 4'hD, 8'hCC, 1'b0);

        toCycle(44);
        applyStimulus(32'hAABBCCDD, 4'b1011);
        toCycle(50); checkOutput("en-c50", 4'hF, 8'hFF, 1'b0);
        toCycle(58); checkOutput("en-c58", 4'h7, 8'hAA, 1'b0);
        toCycle(63); checkOutput("en-c63", 4'h7, 8'hAA, 1'b0);
        toCycle(64); checkOutput("en-c64", 4'hF, 8'hFF, 1'b1);
        toCycle(66); checkOutput("en-c66", 4'hE, 8'hDD, 1'b0);
        toCycle(76); checkOutput("en-c76", 4'hD, 8'hCC, 1'b0);

        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst-mid", 4'hF, 8'hFF, 1'b0);
        display = 32'h55667788;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        toCycle(0);  checkOutput("re-c0",  4'hF, 8'hFF, 1'b1);
        toCycle(2);  checkOutput("re-c2",  4'hE, 8'h88, 1'b0);
        toCycle(18); checkOutput("re-c18", 4'hF, 8'hFF, 1'b0);
        toCycle(26); checkOutput("re-c26", 4'h7, 8'h55, 1'b0);

        for (int i = 0; i < 125; i++) begin
            applyStimulus($urandom, 4'($urandom));
            repeat (7) @(posedge clk);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
Time-multiplexing scanner that sits directly downstream of seg_display. It takes the flattened per-digit cathode bus and drives a common-anode multi-digit 7-segment display one digit at a time, using active-low anodes and active-low cathodes. Each digit slot begins with a blanking interval to suppress ghosting. The input bus is snapshotted once per frame, so a displayed frame is always coherent.

Parameters:
DIGITS, 8, number of digits scanned; must be >= 2.
DIV_CYCLES, 100000, clock cycles per digit slot; must be >= 2.
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must satisfy 1 <= BLANK_CYCLES < DIV_CYCLES.

Ports:
clk  input  1  system clock.
rst  input  1  reset, asynchronous, active-low (0 = reset).
display  input  DIGITS*8  cathode patterns from seg_display; digit i is display[i*8+:8]; active-low segments plus DP.
digit_en  input  DIGITS  per-digit enable; 0 blanks that digit.
anode  output  DIGITS  anode drive, active-low, one-hot-low or all-high.
cathode  output  8  segment drive, active-low.
frame_tick  output  1  one-cycle pulse at the first cycle of each frame.

Behaviour:
- State:
  - cnt: $clog2(DIV_CYCLES) bits, counts 0..DIV_CYCLES-1.
  - idx: $clog2(DIGITS) bits, counts 0..DIGITS-1.
  - fsm: {BLANK, DRIVE}.
  - shadow: DIGITS*8 bits.
- Reset (rst=0, asynchronous), all registers take these values immediately:
  - cnt=0, idx=0, fsm=BLANK, shadow=all 1s.
  - anode=all 1s, cathode=8'hFF, frame_tick=0.
- cnt increments every cycle. At DIV_CYCLES-1 it wraps to 0 and idx increments. idx wraps from DIGITS-1 to 0.
- FSM transitions:
  - BLANK -> DRIVE on the cycle where cnt==BLANK_CYCLES-1.
  - DRIVE -> BLANK on the cycle where cnt==DIV_CYCLES-1. This is the same edge on which idx advances.
- Snapshot: shadow <= display on every clock edge where the next state is cnt==0 and idx==0. This includes the first edge after reset release.
- All outputs are registers computed from next-state values, so each output is aligned with the cnt/idx/fsm value it describes. There is no combinational path from display to the outputs.
- Output rules:
  - In BLANK: anode=all 1s, cathode=8'hFF.
  - In DRIVE with digit_en[idx]=1: anode has only bit idx driven 0; cathode=shadow[idx*8+:8].
  - In DRIVE with digit_en[idx]=0: anode=all 1s, cathode=8'hFF. The slot still consumes DIV_CYCLES, so the refresh rate and brightness of the other digits are unchanged.
- frame_tick=1 exactly in the cycle where cnt==0 and idx==0 (the first cycle after reset release counts). It is 0 otherwise.
- Frame period is DIGITS*DIV_CYCLES cycles.
- display changes mid-frame have no effect until the next snapshot.
- digit_en is sampled live at every slot cycle. No snapshot is taken of it.
- Reset asserted mid-slot: outputs go blank immediately. The scan restarts at idx=0, cnt=0 on release.
- Invariant: at most one anode bit is 0 at any time. Anode is never low during BLANK.

Test Plan:
Use DIGITS=4, DIV_CYCLES=8, BLANK_CYCLES=2 for all scenarios.
1. Reset release, display=32'h11223344, digit_en=4'hF:
   - Cycles 0-1: anode=4'hF.
   - Cycles 2-7: anode=4'hE, cathode=8'h44.
   - Cycles 10-15: anode=4'hD, cathode=8'h33.
   - frame_tick high at cycles 0, 32, 64.
2. Change display to 32'hAABBCCDD at cycle 12 (mid-frame):
   - Digits 1-3 in frame 0 still show the old bytes.
   - Cycles 34-39: cathode=8'hDD.
3. digit_en=4'b1011:
   - Slot 2 (cycles 16-23): anode=4'hF, cathode=8'hFF.
   - Slot 3 is still driven at cycles 26-31.
   - Frame length stays 32.
4. Assert rst at cycle 13 (DRIVE of digit 1):
   - Same cycle, asynchronously: anode=4'hF, cathode=8'hFF, frame_tick=0.
   - After release, the scan restarts at slot 0 with a new snapshot and frame_tick.
5. Run 1000 cycles with random display and digit_en. Assertions:
   - anode is either all 1s or has exactly one 0.
   - anode is never low while cnt<2.
   - frame_tick period is exactly 32.
